// File: rtl/riscv_harness_pkg.sv
// Shared definitions for the RISC-V harness run controller.
//   run_state_e   : controller FSM states
//   RES_*         : 2-bit result codes reported on result_o
//   merge_byte()  : byte-enable merge helper used by the tohost shadow
package riscv_harness_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2
  } run_state_e;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_PASS    = 2'b01;
  localparam logic [1:0] RES_FAIL    = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

  // Returns the new byte when its enable is set, else keeps the old byte.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/tohost_snoop.sv
// Snoops CPU stores to the tohost word, keeps a byte-merged shadow of it and
// raises a pass/fail decision when byte 0 of the location is written.
// Ports:
//   clk_i, rst_ni         : clock, async active-low reset
//   en_i                  : snoop enabled (controller in RUN)
//   memwrite_i, addr_i    : store strobe and word address
//   writedata_i           : store data
//   writemask_i           : byte enables
//   tohost_o              : merged shadow register
//   dec_valid_o           : a decision is made this cycle
//   dec_result_o          : RES_PASS or RES_FAIL, valid with dec_valid_o
module tohost_snoop
  import riscv_harness_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h40
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                memwrite_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   writedata_i,
  input  logic [DATA_W/8-1:0] writemask_i,
  output logic [DATA_W-1:0]   tohost_o,
  output logic                dec_valid_o,
  output logic [1:0]          dec_result_o
);

  localparam int unsigned MaskW = DATA_W / 8;

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] merged;
  logic              hit;

  always_comb begin
    merged = shadow_q;
    for (int i = 0; i < MaskW; i++) begin
      merged[8*i +: 8] = merge_byte(shadow_q[8*i +: 8], writedata_i[8*i +: 8], writemask_i[i]);
    end
  end

  assign hit = en_i && memwrite_i && (addr_i == TOHOST_ADDR);

  always_comb begin
    shadow_d     = shadow_q;
    dec_valid_o  = 1'b0;
    dec_result_o = RES_NONE;
    if (hit) begin
      shadow_d = merged;
      // Byte 0 carries the signature; a merged value of zero means "not yet".
      if (writemask_i[0] && (merged != '0)) begin
        dec_valid_o  = 1'b1;
        dec_result_o = (merged == DATA_W'(1)) ? RES_PASS : RES_FAIL;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign tohost_o = shadow_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for the multicycle RISC-V harness: sequences CPU reset,
// watches for a tohost signature, halt or watchdog expiry, then freezes the
// CPU and pulses a memory-dump request.
// Ports:
//   clk_i, rst_ni                 : clock, async active-low controller reset
//   halt_i                        : CPU halt indication
//   memwrite_i/addr_i/writedata_i/writemask_i : CPU store bus (snooped)
//   cpu_reset_o                   : active-high CPU reset
//   tohost_o                      : merged tohost shadow
//   result_o                      : 00 none, 01 pass, 10 fail, 11 timeout
//   done_o                        : run finished, held until reset
//   dump_req_o                    : one-cycle pulse on entry to DONE
//   cycles_o                      : RUN cycles elapsed, saturating
module riscv_run_ctrl
  import riscv_harness_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       RESET_CYCLES = 2,
  parameter int unsigned       TIMEOUT      = 1200,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h40,
  parameter int unsigned       HALT_HOLD    = 1,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                cpu_reset_o,
  input  logic                halt_i,
  input  logic                memwrite_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   writedata_i,
  input  logic [DATA_W/8-1:0] writemask_i,
  output logic [DATA_W-1:0]   tohost_o,
  output logic [1:0]          result_o,
  output logic                done_o,
  output logic                dump_req_o,
  output logic [CNT_W-1:0]    cycles_o
);

  localparam int unsigned RstCntW  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned HaltCntW = $clog2(HALT_HOLD + 1);

  run_state_e          state_q, state_d;
  logic [RstCntW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [HaltCntW-1:0] halt_cnt_q, halt_cnt_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [1:0]          result_q, result_d;
  logic                dump_q, dump_d;
  logic                halt_fire;
  logic                dec_valid;
  logic [1:0]          dec_result;

  tohost_snoop #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TOHOST_ADDR (TOHOST_ADDR)
  ) u_snoop (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (state_q == RUN),
    .memwrite_i   (memwrite_i),
    .addr_i       (addr_i),
    .writedata_i  (writedata_i),
    .writemask_i  (writemask_i),
    .tohost_o     (tohost_o),
    .dec_valid_o  (dec_valid),
    .dec_result_o (dec_result)
  );

  // This cycle's halt completes HALT_HOLD consecutive high cycles.
  assign halt_fire = halt_i && (halt_cnt_q >= HaltCntW'(HALT_HOLD - 1));

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    halt_cnt_d = halt_cnt_q;
    cycles_d   = cycles_q;
    result_d   = result_q;
    dump_d     = 1'b0;
    unique case (state_q)
      RST_HOLD: begin
        if (rst_cnt_q == RstCntW'(RESET_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!halt_i) begin
          halt_cnt_d = '0;
        end else if (halt_cnt_q != HaltCntW'(HALT_HOLD)) begin
          halt_cnt_d = halt_cnt_q + 1'b1;
        end
        // Priority: tohost decision, then halt, then watchdog.
        if (dec_valid) begin
          result_d = dec_result;
          state_d  = DONE;
        end else if (halt_fire) begin
          state_d = DONE;
        end else if (cycles_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = RES_TIMEOUT;
          state_d  = DONE;
        end else if (cycles_q != '1) begin
          cycles_d = cycles_q + 1'b1;
        end
        dump_d = (state_d == DONE);
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RST_HOLD;
      rst_cnt_q  <= '0;
      halt_cnt_q <= '0;
      cycles_q   <= '0;
      result_q   <= RES_NONE;
      dump_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      halt_cnt_q <= halt_cnt_d;
      cycles_q   <= cycles_d;
      result_q   <= result_d;
      dump_q     <= dump_d;
    end
  end

  assign cpu_reset_o = (state_q != RUN);
  assign done_o      = (state_q == DONE);
  assign dump_req_o  = dump_q;
  assign result_o    = result_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
module tb_riscv_run_ctrl;
  import riscv_harness_pkg::*;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 20;

  logic              clk_i = 1'b1;
  logic              rst_ni;
  logic              cpu_reset_o;
  logic              halt_i;
  logic              memwrite_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] writedata_i;
  logic [3:0]        writemask_i;
  logic [DATA_W-1:0] tohost_o;
  logic [1:0]        result_o;
  logic              done_o;
  logic              dump_req_o;
  logic [CNT_W-1:0]  cycles_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]        res;
    logic [DATA_W-1:0] toh;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  riscv_run_ctrl #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .RESET_CYCLES (2),
    .TIMEOUT      (TIMEOUT),
    .TOHOST_ADDR  (32'h40),
    .HALT_HOLD    (3),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cpu_reset_o (cpu_reset_o),
    .halt_i      (halt_i),
    .memwrite_i  (memwrite_i),
    .addr_i      (addr_i),
    .writedata_i (writedata_i),
    .writemask_i (writemask_i),
    .tohost_o    (tohost_o),
    .result_o    (result_o),
    .done_o      (done_o),
    .dump_req_o  (dump_req_o),
    .cycles_o    (cycles_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".cpu_reset"}, 64'(cpu_reset_o), 64'd1);
    check({tag, ".done"}, 64'(done_o), 64'd0);
    check({tag, ".dump_req"}, 64'(dump_req_o), 64'd0);
    check({tag, ".result"}, 64'(result_o), 64'(RES_NONE));
    check({tag, ".tohost"}, 64'(tohost_o), 64'd0);
    check({tag, ".cycles"}, 64'(cycles_o), 64'd0);
  endtask

  // Called at a negedge with reset asserted; CPU reset must drop after two edges.
  task automatic release_and_run(input string tag);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check({tag, ".cpu_reset_edge1"}, 64'(cpu_reset_o), 64'd1);
    @(negedge clk_i);
    check({tag, ".cpu_reset_edge2"}, 64'(cpu_reset_o), 64'd0);
    check({tag, ".cycles_start"}, 64'(cycles_o), 64'd0);
    check({tag, ".dump_idle"}, 64'(dump_req_o), 64'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_reset_vals({tag, ".async"});
    @(negedge clk_i);
    release_and_run(tag);
  endtask

  // Presents one store for a single rising edge; returns at the following negedge.
  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [3:0] m);
    memwrite_i  = 1'b1;
    addr_i      = a;
    writedata_i = d;
    writemask_i = m;
    @(negedge clk_i);
    memwrite_i  = 1'b0;
    writemask_i = 4'b0000;
  endtask

  task automatic wait_done(input string tag, input int budget);
    exp_t e;
    int   k = 0;
    while (!done_o && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check({tag, ".done"}, 64'(done_o), 64'd1);
    check({tag, ".dump_first"}, 64'(dump_req_o), 64'd1);
    check({tag, ".cpu_frozen"}, 64'(cpu_reset_o), 64'd1);
    check({tag, ".sb_depth"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, ".result"}, 64'(result_o), 64'(e.res));
      check({tag, ".tohost"}, 64'(tohost_o), 64'(e.toh));
    end
    @(negedge clk_i);
    check({tag, ".dump_once"}, 64'(dump_req_o), 64'd0);
    check({tag, ".done_held"}, 64'(done_o), 64'd1);
  endtask

  function automatic exp_t mk(input logic [1:0] r, input logic [DATA_W-1:0] t);
    exp_t e;
    e.res = r;
    e.toh = t;
    return e;
  endfunction

  initial begin
    rst_ni      = 1'b0;
    halt_i      = 1'b0;
    memwrite_i  = 1'b0;
    addr_i      = '0;
    writedata_i = '0;
    writemask_i = 4'b0000;

    // Power-on reset, released at t=15.
    #1;
    check_reset_vals("por");
    #13;
    @(negedge clk_i);
    release_and_run("por");
    @(negedge clk_i);
    check("por.cycles_inc", 64'(cycles_o), 64'd1);

    // Full-word passing signature.
    sb_q.push_back(mk(RES_PASS, 32'h1));
    store(32'h40, 32'h1, 4'b1111);
    wait_done("pass", 0);
    // Stores in DONE are ignored.
    store(32'h40, 32'h2, 4'b1111);
    check("done.tohost_frozen", 64'(tohost_o), 64'h1);
    check("done.result_frozen", 64'(result_o), 64'(RES_PASS));

    // Byte merging; zero, wrong address and empty mask make no decision.
    apply_reset("bytes");
    store(32'h40, 32'h0, 4'b1111);
    check("zero.done", 64'(done_o), 64'd0);
    store(32'h44, 32'hFFFF_FFFF, 4'b1111);
    check("miss.tohost", 64'(tohost_o), 64'h0);
    store(32'h40, 32'h0000_AB00, 4'b0010);
    check("byte1.tohost", 64'(tohost_o), 64'h0000_AB00);
    check("byte1.done", 64'(done_o), 64'd0);
    check("byte1.result", 64'(result_o), 64'(RES_NONE));
    store(32'h40, 32'hFFFF_FFFF, 4'b0000);
    check("mask0.tohost", 64'(tohost_o), 64'h0000_AB00);
    check("mask0.done", 64'(done_o), 64'd0);
    sb_q.push_back(mk(RES_FAIL, 32'h0000_AB05));
    store(32'h40, 32'h0000_0005, 4'b0001);
    wait_done("fail", 0);

    // Reset in DONE, then reset in the middle of RUN.
    apply_reset("in_done");
    store(32'h40, 32'h0000_CD00, 4'b0010);
    @(negedge clk_i);
    check("midrun.tohost_pre", 64'(tohost_o), 64'h0000_CD00);
    apply_reset("midrun");

    // Halt debounce: 2 high, 1 low, 3 high.
    halt_i = 1'b1;
    @(negedge clk_i);
    check("halt.h1", 64'(done_o), 64'd0);
    @(negedge clk_i);
    check("halt.h2", 64'(done_o), 64'd0);
    halt_i = 1'b0;
    @(negedge clk_i);
    check("halt.low", 64'(done_o), 64'd0);
    halt_i = 1'b1;
    @(negedge clk_i);
    check("halt.h1b", 64'(done_o), 64'd0);
    @(negedge clk_i);
    check("halt.h2b", 64'(done_o), 64'd0);
    sb_q.push_back(mk(RES_NONE, 32'h0));
    @(negedge clk_i);
    halt_i = 1'b0;
    wait_done("halt", 0);

    // Watchdog.
    apply_reset("wdog");
    sb_q.push_back(mk(RES_TIMEOUT, 32'h0));
    wait_done("timeout", 40);
    check("timeout.cycles", 64'(cycles_o), 64'(TIMEOUT - 1));

    // Passing store in the same cycle the watchdog would fire.
    apply_reset("race");
    for (int k = 0; k < 40 && cycles_o != CNT_W'(TIMEOUT - 1); k++) begin
      @(negedge clk_i);
    end
    check("race.cycles_pre", 64'(cycles_o), 64'(TIMEOUT - 1));
    check("race.not_done", 64'(done_o), 64'd0);
    sb_q.push_back(mk(RES_PASS, 32'h1));
    store(32'h40, 32'h1, 4'b1111);
    wait_done("race", 0);
    check("race.cycles_frozen", 64'(cycles_o), 64'(TIMEOUT - 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_run_ctrl.md
Name: riscv_run_ctrl

Overview:
Synthesizable run controller for the multicycle RISC-V simulation and FPGA harness. It sequences the CPU reset and snoops the CPU data bus for a byte-masked "tohost" signature store. It detects halt, enforces a cycle watchdog and issues a one-cycle memory-dump request. It is the parametrised successor to fixed-time harness control: configurable timeout, tohost address, halt debounce, data width and pass/fail result codes.

Parameters:
ADDR_W, 32, CPU address width
DATA_W, 32, CPU data width (multiple of 8); mask width = DATA_W/8
RESET_CYCLES, 2, cycles cpu_reset held after controller reset release (>=1)
TIMEOUT, 1200, RUN cycles before watchdog fires (>=2)
TOHOST_ADDR, 'h40, word address of the signature location
HALT_HOLD, 1, consecutive cycles halt must be high to count (>=1)
CNT_W, 32, width of cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low controller reset
cpu_reset  out  1  active-high reset driven to CPU
halt  in  1  CPU halt indication
memwrite  in  1  CPU store strobe
addr  in  ADDR_W  CPU data address
writedata  in  DATA_W  CPU store data
writemask  in  DATA_W/8  byte enables of store
tohost  out  DATA_W  merged shadow of tohost location
result  out  2  00 none, 01 pass, 10 fail, 11 timeout
done  out  1  run finished, held until reset
dump_req  out  1  one-cycle pulse on entry to DONE
cycles  out  CNT_W  RUN cycles elapsed, saturating

Behaviour:
- Reset (reset=0, async): state=RST_HOLD, cpu_reset=1, tohost=0, result=00, done=0, dump_req=0, cycles=0, hold/halt counters=0.
- RST_HOLD: count RESET_CYCLES clk edges after reset release, then go to RUN. cpu_reset deasserts on the same edge RUN is entered.
- RUN: cycles increments each cycle, saturating at all-ones.
- Tohost snoop, in RUN only: a store hits when memwrite=1 and addr==TOHOST_ADDR. The shadow merges each byte i where writemask[i]=1. Unmasked bytes keep their value.
- Evaluation happens on a hit with writemask[0]=1, using the merged value: value==1 -> result=01; nonzero, not 1 -> result=10; zero -> no decision. Any decision -> DONE next edge.
- A hit with mask 0 updates nothing.
- Halt: a saturating counter of consecutive halt=1 cycles, cleared by halt=0. Reaching HALT_HOLD -> DONE with result unchanged (00 if no signature).
- Watchdog: when cycles reaches TIMEOUT-1 in RUN with no other decision that cycle -> DONE, result=11.
- Priority in the same cycle: tohost decision > halt > timeout.
- DONE: done=1, cpu_reset=1 (CPU frozen), cycles frozen, result and tohost frozen. dump_req=1 exactly on the first DONE cycle only. All snoop inputs are ignored. DONE exits only via reset.
- Latency: a qualifying store at edge N gives result and done visible after edge N+1, with dump_req high in that same cycle.
- Reset mid-run: immediate return to RST_HOLD with all outputs at reset values. No dump_req is generated.
- The tohost output reflects the merged shadow one cycle after each hit.

Decomposition:
- Shared package riscv_harness_pkg holds:
  - state enum {RST_HOLD, RUN, DONE};
  - result codes RES_NONE, RES_PASS, RES_FAIL, RES_TIMEOUT;
  - a function that applies a byte mask to merge data.
- One sub-module is natural: tohost_snoop, which does address match, byte merge and decision generation.
- The FSM, watchdog and halt debounce stay in riscv_run_ctrl.

Test Plan:
- Release reset at t=15 with RESET_CYCLES=2 -> cpu_reset falls exactly 2 edges later; cycles counts from 0.
- Store to 'h40, mask 1111, data 1 -> next cycle result=01, done=1, dump_req pulses for exactly one cycle, cpu_reset=1.
- Byte stores to 'h40: mask 0010 data 'h0000AB00, then mask 0001 data 'h00000005 -> tohost='h0000AB05, result=10 after the second store only.
- halt high with HALT_HOLD=3 for 2 cycles, low, then 3 cycles -> done only after the third consecutive cycle; result=00.
- TIMEOUT=20, no stores, no halt -> done at cycles=19, result=11. Same cycle as a passing tohost store -> result=01.
- Assert reset mid-RUN and again in DONE -> all outputs return to reset values asynchronously, and the controller reruns cleanly.
